// File: rtl/effect_sequencer.sv
// Audio effect sequencer: queues codec samples in a FIFO and hands them one at a
// time to an external effect over a START/DONE handshake, with bypass and timeout fallback.
module effect_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               in_valid,
  input  logic signed [15:0] in_sample,
  input  logic               bypass,
  output logic               fx_start,
  output logic signed [15:0] fx_sample,
  input  logic               fx_done,
  input  logic signed [15:0] fx_result,
  output logic               out_valid,
  output logic signed [15:0] out_sample,
  input  logic               out_ready,
  output logic               busy,
  output logic               overflow,
  output logic               timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic signed [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;
  logic signed [15:0] cur;
  logic [CW-1:0]      tmo_cnt;

  logic               full, empty, push, pop, drop;
  logic               out_load, out_clr, tmo_hit, cnt_clr, cnt_inc;
  logic signed [15:0] out_nxt;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  // A full FIFO still accepts a sample when the head leaves in the same cycle.
  assign push      = in_valid && !RESET && (!full || pop);
  assign drop      = in_valid && !RESET && full && !pop;
  assign fx_sample = cur;
  assign busy      = (state != IDLE) || !empty;

  // NOTE: every signal driven here is given a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    fx_start  = 1'b0;
    out_load  = 1'b0;
    out_nxt   = cur;
    out_clr   = 1'b0;
    tmo_hit   = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty && !out_valid) begin
          pop       = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        cnt_clr = 1'b1;
        if (bypass) begin
          out_load  = 1'b1;
          state_nxt = HOLD;
        end else begin
          fx_start  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // DONE takes priority over a timeout landing in the same cycle.
        if (fx_done) begin
          out_load  = 1'b1;
          out_nxt   = fx_result;
          state_nxt = HOLD;
        end else if (tmo_cnt == TMO_LAST) begin
          out_load  = 1'b1;
          tmo_hit   = 1'b1;
          state_nxt = HOLD;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      cur         <= '0;
      tmo_cnt     <= '0;
      out_valid   <= 1'b0;
      out_sample  <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        cur    <= mem[rd_ptr];
      end
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (drop) overflow <= 1'b1;
      if (cnt_clr)      tmo_cnt <= '0;
      else if (cnt_inc) tmo_cnt <= tmo_cnt + 1'b1;
      if (out_load) begin
        out_valid  <= 1'b1;
        out_sample <= out_nxt;
      end else if (out_clr) begin
        out_valid <= 1'b0;
      end
      if (tmo_hit) timeout_err <= 1'b1;
    end
  end

  // NOTE: the sample array is not reset; the cleared pointers and count make stale entries unreachable.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= in_sample;
  end
endmodule

// File: tb/tb_effect_sequencer.sv
// Directed bench for effect_sequencer: latency, bypass, timeout, FIFO full/overflow and reset abort.
// Cycle T+n is the cycle that ends at edge T+n, so "out_valid at T+4" is visible just after edge T+3.
module tb_effect_sequencer;
  logic        CLK = 1'b0;
  logic        RESET, in_valid, bypass, fx_done, out_ready;
  logic [15:0] in_sample, fx_result, fx_sample, out_sample;
  logic        fx_start, out_valid, busy, overflow, timeout_err;

  int          total = 0, bad = 0, cyc = 0, starts = 0;
  bit          model_en = 1'b0, pending = 1'b0, ov_seen = 1'b0;
  logic [15:0] pend_smp = '0;
  logic [15:0] got[$];

  effect_sequencer dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .in_valid   (in_valid),
    .in_sample  (in_sample),
    .bypass     (bypass),
    .fx_start   (fx_start),
    .fx_sample  (fx_sample),
    .fx_done    (fx_done),
    .fx_result  (fx_result),
    .out_valid  (out_valid),
    .out_sample (out_sample),
    .out_ready  (out_ready),
    .busy       (busy),
    .overflow   (overflow),
    .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, act, exp);
    end
  endtask

  // One clock: observe pre-edge outputs, cross the edge, then drive the effect model
  // (DONE one cycle after START, result = sample * 2).
  task automatic tick();
    #1;
    pending  = fx_start;
    pend_smp = fx_sample;
    if (fx_start) starts++;
    if (out_valid) ov_seen = 1'b1;
    if (out_valid && out_ready && !RESET) got.push_back(out_sample);
    @(posedge CLK);
    #1;
    cyc++;
    if (cyc > 20000) begin
      $display("FAIL cycle_budget: got=%0d want<=20000", cyc);
      $fatal(1, "cycle budget exhausted");
    end
    fx_done   = model_en && pending;
    fx_result = pending ? (pend_smp << 1) : 16'h0000;
  endtask

  task automatic push(input logic [15:0] s);
    in_valid  = 1'b1;
    in_sample = s;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET   = 1'b0;
    fx_done = 1'b0;
    got.delete();
  endtask

  initial begin
    RESET = 1'b1; in_valid = 1'b1; in_sample = 16'h7777;
    bypass = 1'b0; fx_done = 1'b0; fx_result = '0; out_ready = 1'b1;
    tick();
    tick();
    RESET = 1'b0; in_valid = 1'b0;
    check("rst_busy", busy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_fx_start", fx_start, 0);
    check("rst_fx_sample", fx_sample, 0);
    check("rst_out_sample", out_sample, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout_err, 0);
    tick();
    check("rst_in_ignored", busy, 0);

    // Effect path: 0x0100 -> 0x0200, START at T+2, out_valid at T+4.
    model_en = 1'b1; starts = 0; got.delete();
    push(16'h0100);
    check("a_busy_T", busy, 1);
    tick();
    check("a_start_T2", fx_start, 1);
    check("a_fx_sample", fx_sample, 16'h0100);
    tick();
    check("a_start_T3", fx_start, 0);
    check("a_ov_T3", out_valid, 0);
    tick();
    check("a_ov_T4", out_valid, 1);
    check("a_out_sample", out_sample, 16'h0200);
    tick();
    check("a_ov_clear", out_valid, 0);
    check("a_busy_end", busy, 0);
    check("a_starts", starts, 1);
    check("a_got_n", got.size(), 1);

    // Bypass: no START, out_valid at T+3.
    bypass = 1'b1; starts = 0; got.delete();
    push(16'h8001);
    tick();
    check("b_start", fx_start, 0);
    check("b_ov_T2", out_valid, 0);
    tick();
    check("b_ov_T3", out_valid, 1);
    check("b_out_sample", out_sample, 16'h8001);
    tick();
    check("b_starts", starts, 0);
    check("b_got_n", got.size(), 1);
    bypass = 1'b0;

    // Timeout: no DONE, dry sample after TIMEOUT WAIT cycles, sticky error.
    model_en = 1'b0; out_ready = 1'b0;
    push(16'h1234);
    repeat (16) tick();
    check("c_ov_early", out_valid, 0);
    check("c_tmo_early", timeout_err, 0);
    tick();
    check("c_ov", out_valid, 1);
    check("c_out_sample", out_sample, 16'h1234);
    check("c_tmo", timeout_err, 1);
    fx_done = 1'b1; fx_result = 16'h5555;
    tick();
    check("c_done_ignored", out_sample, 16'h1234);
    check("c_hold", out_valid, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("c_ov_clear", out_valid, 0);
    repeat (3) tick();
    check("c_tmo_sticky", timeout_err, 1);
    do_reset();
    check("c_tmo_reset", timeout_err, 0);

    // Nine back-to-back samples with out_ready low: one held, eight queued, tenth dropped.
    bypass = 1'b1; out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      in_valid = 1'b1; in_sample = 16'(i);
      tick();
    end
    check("d_count8", dut.count, 8);
    check("d_ovf0", overflow, 0);
    check("d_hold_first", out_sample, 16'h0001);
    in_sample = 16'd10;
    tick();
    in_valid = 1'b0;
    check("d_ovf1", overflow, 1);
    check("d_count_after_drop", dut.count, 8);
    out_ready = 1'b1;
    repeat (40) tick();
    check("d_got_n", got.size(), 9);
    foreach (got[i]) check($sformatf("d_order%0d", i), got[i], 32'(i + 1));
    check("d_busy_end", busy, 0);

    // Full FIFO, push coincident with pop: accepted, count stays 8.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1; in_sample = 16'(21 + i);
      tick();
    end
    in_valid = 1'b0;
    check("e_count8", dut.count, 8);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    push(16'd30);
    check("e_count_keep", dut.count, 8);
    check("e_ovf0", overflow, 0);
    out_ready = 1'b1;
    repeat (40) tick();
    check("e_got_n", got.size(), 10);
    foreach (got[i]) check($sformatf("e_order%0d", i), got[i], 32'(21 + i));

    // Reset during WAIT with three samples queued.
    do_reset();
    bypass = 1'b0; model_en = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_sample = 16'(41 + i);
      tick();
    end
    in_valid = 1'b0;
    check("f_in_wait", dut.state, 2);
    check("f_queued3", dut.count, 3);
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    check("f_state_idle", dut.state, 0);
    check("f_busy", busy, 0);
    check("f_out_valid", out_valid, 0);
    check("f_count0", dut.count, 0);
    got.delete(); ov_seen = 1'b0;
    fx_done = 1'b1; fx_result = 16'h7FFF;
    tick();
    repeat (10) tick();
    check("f_no_output", got.size(), 0);
    check("f_no_valid", ov_seen, 0);
    check("f_busy_end", busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/effect_sequencer.md
EFFECT_SEQUENCER -- requirements
Module: effect_sequencer

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 8, giving the number of input sample slots (power of two, 2..64).
REQ-002 The block SHALL have parameter TIMEOUT, default 15, giving the maximum number of cycles spent in WAIT before aborting.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-004 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the codec-side sample strobe.
REQ-006 The block SHALL have port in_sample, input, 16 bits signed: the codec sample.
REQ-007 The block SHALL have port bypass, input, 1 bit: when 1, the sample skips the effect stage.
REQ-008 The block SHALL have port fx_start, output, 1 bit: START to the downstream effect.
REQ-009 The block SHALL have port fx_sample, output, 16 bits signed: the sample presented to the effect.
REQ-010 The block SHALL have port fx_done, input, 1 bit: DONE from the effect.
REQ-011 The block SHALL have port fx_result, input, 16 bits signed: the effect output sample.
REQ-012 The block SHALL have port out_valid, output, 1 bit: a processed sample is available.
REQ-013 The block SHALL have port out_sample, output, 16 bits signed: the processed sample.
REQ-014 The block SHALL have port out_ready, input, 1 bit: the DAC side accepts out_sample.
REQ-015 The block SHALL have port busy, output, 1 bit: high when the state is not IDLE or the FIFO is non-empty.
REQ-016 The block SHALL have port overflow, output, 1 bit: sticky flag for a dropped input sample.
REQ-017 The block SHALL have port timeout_err, output, 1 bit: sticky flag for an effect timeout.

Function
REQ-018 The input FIFO SHALL be FIFO_DEPTH x 16 with a fill count of 0..FIFO_DEPTH, and its read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-019 When in_valid=1, the FIFO SHALL write in_sample if it is not full, or if a pop occurs in the same cycle.
REQ-020 When in_valid=1, the FIFO is full and no pop occurs in that cycle, the sample SHALL be dropped and overflow SHALL be set.
REQ-021 A simultaneous push and pop SHALL leave the fill count unchanged.
REQ-022 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT and HOLD.
REQ-023 IDLE with a non-empty FIFO SHALL pop the head into the cur register and go to ISSUE on the next edge.
REQ-024 IDLE with an empty FIFO SHALL stay in IDLE.
REQ-025 ISSUE with bypass=0 SHALL assert fx_start for exactly one cycle, set fx_sample=cur, clear the timeout counter and go to WAIT.
REQ-026 ISSUE with bypass=1 SHALL load out_sample=cur, set out_valid=1 and go to HOLD, with fx_start staying 0.
REQ-027 fx_sample SHALL stay equal to cur from ISSUE until WAIT exits.
REQ-028 WAIT with fx_done=1 SHALL register out_sample=fx_result, set out_valid=1 and go to HOLD.
REQ-029 WAIT with fx_done=0 SHALL increment the counter.
REQ-030 WAIT with the counter reaching TIMEOUT and fx_done=0 SHALL set out_sample=cur (the dry sample), set out_valid=1, set timeout_err and go to HOLD.
REQ-031 When fx_done=1 and the timeout occur in the same cycle, fx_done SHALL win.
REQ-032 fx_done SHALL be ignored in every state except WAIT.
REQ-033 HOLD SHALL keep out_valid=1 and out_sample stable until out_ready=1.
REQ-034 HOLD with out_ready=1 SHALL clear out_valid on that edge and go to IDLE.
REQ-035 No FIFO pop SHALL occur while out_valid=1.
REQ-036 Latency SHALL be as follows, with T the edge at which a sample is written into an empty FIFO while the FSM is IDLE: fx_start is high in cycle T+2 (the cycle after the ISSUE transition).
REQ-037 With an effect that returns DONE one cycle after START, out_valid SHALL rise at T+4.
REQ-038 In bypass the corresponding out_valid SHALL rise at T+3.
REQ-039 Sample order SHALL be preserved, with no duplication and no loss of any accepted sample.
REQ-040 fx_result SHALL be passed through unmodified; the block SHALL perform no saturation or gain of its own.

Reset
REQ-041 RESET=1 at an edge SHALL empty the FIFO, zero both pointers and the count, and force the state to IDLE.
REQ-042 RESET=1 at an edge SHALL set fx_start=0, fx_sample=0, out_valid=0, out_sample=0, overflow=0, timeout_err=0 and busy=0.
REQ-043 Reset asserted mid-operation in any state SHALL discard the in-flight sample and SHALL NOT emit out_valid.
REQ-044 in_valid sampled during reset SHALL be ignored.

Verification
REQ-045 Bench: a single sample 0x0100 with bypass=0, the model effect returning fx_result=0x0200 with DONE one cycle after START, out_ready=1 -> exactly one fx_start pulse, out_sample=0x0200 with out_valid at T+4, then busy=0.
REQ-046 Bench: bypass=1 with sample 0x8001 -> fx_start never asserted, out_sample=0x8001 with out_valid at T+3.
REQ-047 Bench: fx_done tied 0 with sample 0x1234 -> out_sample=0x1234 after TIMEOUT WAIT cycles, timeout_err=1 and held until reset.
REQ-048 Bench: out_ready=0 while 9 consecutive samples are written with FIFO_DEPTH=8 -> the first sample sits in HOLD, the next 8 fill the FIFO, no drop and overflow=0; a 10th sample -> overflow=1; release out_ready -> outputs 1..9 in order.
REQ-049 Bench: FIFO full with a push in the same cycle as a pop -> sample accepted, count stays 8, overflow stays 0.
REQ-050 Bench: RESET asserted during WAIT with 3 samples queued -> the next cycle shows state IDLE, busy=0, no out_valid, and a later fx_done pulse produces no output.
